// File: rtl/mem_bus_pkg.sv
// Shared definitions for the SRAM-like bus bridges: FSM encoding, bus size
// codes and the kseg0/kseg1 address-window constants.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Top two address bits selecting the kseg0/kseg1 window, and how many
    // top bits are cleared to form the physical address inside it.
    localparam logic [1:0] KSEG_SEG      = 2'b10;
    localparam int         KSEG_CLR_BITS = 3;

endpackage

// File: rtl/strb2size.sv
// Combinational decoder from store byte enables to bus transfer size.
// Irregular enable patterns fall back to a full word.
module strb2size
    import mem_bus_pkg::*;
(
    input  logic [3:0] strb_i,
    output logic [1:0] size_o
);

    always_comb begin
        // NOTE: default assignment first so no path leaves size_o unassigned (no latch).
        size_o = SZ_WORD;
        unique case (strb_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SZ_BYTE;
            4'b0011, 4'b1100:                   size_o = SZ_HALF;
            default:                            size_o = SZ_WORD;
        endcase
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// MEM-stage data bridge: turns one load/store per instruction into a single
// req/addr_ok/data_ok transaction on the SRAM-like bus and stalls the pipe until done.
module dmem_sram_bridge
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        load_size,
    input  logic [3:0]        sig_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic [DATA_W-1:0] readdataM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dmem_state_t       state_q;
    logic              req_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;

    logic              acc;
    logic [1:0]        st_size;
    logic [1:0]        size_d;
    logic [3:0]        wstrb_d;
    logic [ADDR_W-1:0] addr_d;

    strb2size u_strb2size (
        .strb_i (sig_write),
        .size_o (st_size)
    );

    assign acc = mem_rd | mem_wr;

    // A store wins when both requests are raised together.
    always_comb begin
        size_d  = mem_wr ? st_size : load_size;
        wstrb_d = mem_wr ? sig_write : 4'b0000;
        addr_d  = addr;
        if (addr[ADDR_W-1 -: 2] == KSEG_SEG) begin
            addr_d[ADDR_W-1 -: KSEG_CLR_BITS] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        req_q   <= 1'b1;
                        wr_q    <= mem_wr;
                        size_q  <= size_d;
                        wstrb_q <= wstrb_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        rbuf_q  <= data_rdata;
                        state_q <= longest_stall ? ST_DONE : ST_IDLE;
                    end
                end
                // Hold here until the pipeline moves, so the held instruction is not reissued.
                ST_DONE: begin
                    if (!longest_stall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

    assign d_stall   = ((state_q == ST_IDLE) && acc) || (state_q == ST_REQ) ||
                       ((state_q == ST_WAIT) && !data_data_ok);
    assign readdataM = ((state_q == ST_WAIT) && data_data_ok) ? data_rdata : rbuf_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: acts as both pipeline and bus slave,
// comparing every cycle against expectations derived from the access itself.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr, longest_stall;
    logic [1:0]  load_size;
    logic [3:0]  sig_write;
    logic [31:0] addr, wdata;
    logic        d_stall;
    logic [31:0] readdataM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model_rbuf = 32'h0;

    always #5 clk = ~clk;

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .load_size     (load_size),
        .sig_write     (sig_write),
        .addr          (addr),
        .wdata         (wdata),
        .longest_stall (longest_stall),
        .d_stall       (d_stall),
        .readdataM     (readdataM),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_wstrb    (data_wstrb),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va & 32'h1FFF_FFFF;
        return va;
    endfunction

    function automatic logic [1:0] store_size(input logic [3:0] sw);
        case (sw)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 2'd0;
            4'b0011, 4'b1100:                   return 2'd1;
            default:                            return 2'd2;
        endcase
    endfunction

    task automatic scramble_bus_inputs();
        addr       = $urandom;
        wdata      = $urandom;
        sig_write  = 4'($urandom);
        load_size  = 2'($urandom);
        data_rdata = $urandom;
    endtask

    task automatic idle_cycle();
        mem_rd = 1'b0; mem_wr = 1'b0;
        longest_stall = 1'($urandom);
        data_addr_ok  = 1'($urandom);
        data_data_ok  = 1'($urandom);
        data_rdata    = $urandom;
        @(negedge clk);
        check("idle_d_stall", 32'(d_stall), 32'd0);
        check("idle_req", 32'(data_req), 32'd0);
        check("idle_rdata", readdataM, model_rbuf);
        @(posedge clk); #1;
    endtask

    // One complete access: request in cycle 0, addr_ok after aok_w extra REQ cycles,
    // data_ok after dok_w extra WAIT cycles, then longest_stall held for 'extra' cycles.
    task automatic access(input bit rd, input bit wr, input logic [1:0] ls,
                          input logic [3:0] sw, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int aok_w, input int dok_w,
                          input int extra);
        logic [31:0] e_addr;
        logic [1:0]  e_size;
        logic [3:0]  e_strb;
        int          req_cycles;
        e_addr = phys(a);
        e_size = wr ? store_size(sw) : ls;
        e_strb = wr ? sw : 4'b0000;
        req_cycles = 0;

        mem_rd = rd; mem_wr = wr; load_size = ls; sig_write = sw; addr = a; wdata = wd;
        longest_stall = 1'($urandom);
        data_addr_ok  = 1'($urandom);
        data_data_ok  = 1'($urandom);
        data_rdata    = $urandom;
        @(negedge clk);
        check("c0_d_stall", 32'(d_stall), 32'd1);
        check("c0_req", 32'(data_req), 32'd0);
        check("c0_rdata", readdataM, model_rbuf);
        @(posedge clk); #1;

        for (int i = 0; i <= aok_w; i++) begin
            scramble_bus_inputs();
            longest_stall = 1'($urandom);
            data_addr_ok  = (i == aok_w);
            data_data_ok  = 1'($urandom);
            @(negedge clk);
            if (data_req) req_cycles++;
            check("req_d_stall", 32'(d_stall), 32'd1);
            check("req_addr", data_addr, e_addr);
            check("req_size", 32'(data_size), 32'(e_size));
            check("req_wstrb", 32'(data_wstrb), 32'(e_strb));
            check("req_wr", 32'(data_wr), 32'(wr));
            if (wr) check("req_wdata", data_wdata, wd);
            check("req_rdata", readdataM, model_rbuf);
            @(posedge clk); #1;
        end
        check("req_pulse_len", 32'(req_cycles), 32'(aok_w + 1));

        for (int j = 0; j <= dok_w; j++) begin
            scramble_bus_inputs();
            data_addr_ok  = 1'($urandom);
            data_data_ok  = (j == dok_w);
            longest_stall = (j == dok_w) ? (extra > 0) : 1'($urandom);
            if (j == dok_w) data_rdata = rdat;
            @(negedge clk);
            check("wait_req", 32'(data_req), 32'd0);
            check("wait_d_stall", 32'(d_stall), (j == dok_w) ? 32'd0 : 32'd1);
            check("wait_rdata", readdataM, (j == dok_w) ? rdat : model_rbuf);
            @(posedge clk); #1;
        end
        model_rbuf = rdat;

        if (extra > 0) begin
            for (int k = 0; k <= extra; k++) begin
                mem_rd = rd; mem_wr = wr; load_size = ls; sig_write = sw; addr = a; wdata = wd;
                longest_stall = (k < extra);
                data_addr_ok  = 1'($urandom);
                data_data_ok  = 1'($urandom);
                data_rdata    = $urandom;
                @(negedge clk);
                check("done_d_stall", 32'(d_stall), 32'd0);
                check("done_req", 32'(data_req), 32'd0);
                check("done_rdata", readdataM, model_rbuf);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; longest_stall = 1'b0;
        load_size = 2'd0; sig_write = 4'd0; addr = 32'd0; wdata = 32'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #2;
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_wr", 32'(data_wr), 32'd0);
        check("rst_size", 32'(data_size), 32'd0);
        check("rst_wstrb", 32'(data_wstrb), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_readdata", readdataM, 32'd0);
        check("rst_d_stall_idle", 32'(d_stall), 32'd0);
        mem_rd = 1'b1; #1;
        check("rst_d_stall_acc", 32'(d_stall), 32'd1);
        mem_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Store word into kseg0, data_ok two cycles after addr_ok.
        access(1'b0, 1'b1, 2'd0, 4'b1111, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1, 0);
        idle_cycle();
        // Load byte from kseg1 at minimum latency.
        access(1'b1, 1'b0, 2'd0, 4'b0000, 32'hBFC0_0003, 32'h0, 32'h1122_3344, 0, 0, 0);
        idle_cycle();
        // addr_ok withheld for 5 cycles.
        access(1'b1, 1'b0, 2'd2, 4'b0000, 32'h0000_1234, 32'h0, 32'hCAFE_0001, 5, 0, 0);
        // Load completing under a 3-cycle global stall.
        access(1'b1, 1'b0, 2'd1, 4'b0000, 32'h9000_0042, 32'h0, 32'h5566_7788, 0, 1, 3);
        idle_cycle();
        // Store halfword immediately followed by a load, plus a rd+wr collision.
        access(1'b0, 1'b1, 2'd0, 4'b1100, 32'hC000_0002, 32'hABCD_0000, 32'h1357_9BDF, 1, 0, 0);
        access(1'b1, 1'b0, 2'd2, 4'b0000, 32'h7FFF_FFFC, 32'h0, 32'h2468_ACE0, 0, 0, 0);
        access(1'b1, 1'b1, 2'd0, 4'b0110, 32'hA000_0000, 32'h1234_5678, 32'h0F0F_0F0F, 0, 0, 0);
        idle_cycle();

        // Reset while waiting for data_ok.
        mem_rd = 1'b1; mem_wr = 1'b0; load_size = 2'd2; addr = 32'h8000_0100;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; longest_stall = 1'b0;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        check("pre_rst_addr", data_addr, 32'h0000_0100);
        #1 rst = 1'b0;
        #1;
        check("async_rst_addr", data_addr, 32'd0);
        check("async_rst_req", 32'(data_req), 32'd0);
        check("async_rst_readdata", readdataM, 32'd0);
        check("async_rst_d_stall", 32'(d_stall), 32'd1);
        mem_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_rbuf = 32'd0;
        data_data_ok = 1'b1; data_rdata = 32'hFFEE_DDCC;
        @(negedge clk);
        check("late_ok_readdata", readdataM, 32'd0);
        check("late_ok_d_stall", 32'(d_stall), 32'd0);
        @(posedge clk); #1;
        idle_cycle();

        // Randomized accesses.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            logic [3:0]  sw;
            logic [31:0] bnd [4];
            bnd[0] = 32'h7FFF_FFFF; bnd[1] = 32'h8000_0000;
            bnd[2] = 32'hBFFF_FFFF; bnd[3] = 32'hC000_0000;
            kind = int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       a = ($urandom & 32'h3FFF_FFFF) | 32'h8000_0000;
                1:       a = bnd[$urandom_range(0, 3)];
                default: a = $urandom;
            endcase
            sw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0001 << $urandom_range(0, 3);
            access(kind != 1, kind != 0, 2'($urandom_range(0, 2)), sw, a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
